// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy, threshold flags, sticky errors and optional FWFT read
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int PTR_WIDTH     = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] AF_T = (PTR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wptr_q, wptr_d;
    logic [PTR_WIDTH:0]    rptr_q, rptr_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc, rd_acc;

    // Flags come only from registered pointers, never from the request inputs.
    assign count        = wptr_q - rptr_q;
    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                          (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    always_comb begin
        wptr_d = wptr_q + {{PTR_WIDTH{1'b0}}, wr_acc};
        rptr_d = rptr_q + {{PTR_WIDTH{1'b0}}, rd_acc};
        ovf_d  = clr_err ? 1'b0 : ovf_q;
        unf_d  = clr_err ? 1'b0 : unf_q;
        // A new error in the same cycle as clr_err must survive the clear.
        if (w_en && full) begin
            ovf_d = 1'b1;
        end
        if (r_en && empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q[PTR_WIDTH-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rptr_q[PTR_WIDTH-1:0]];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rptr_q[PTR_WIDTH-1:0]];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized queue-model bench driving standard and FWFT instances side by side
module tb_sync_fifo_flags;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic [DW-1:0] data_in;
    logic          r_en;
    logic          clr_err;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [PW:0]   s_count, f_count;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_dout;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .clr_err(clr_err), .data_out(s_dout), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(PW),
                      .AFULL_THRESH(12), .AEMPTY_THRESH(2), .FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .clr_err(clr_err), .data_out(f_dout), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    task automatic compare();
        int n;
        n = q.size();
        chk("count",     32'(s_count), n);
        chk("fw_count",  32'(f_count), n);
        chk("full",      32'(s_full),  32'(n == DEPTH));
        chk("fw_full",   32'(f_full),  32'(n == DEPTH));
        chk("empty",     32'(s_empty), 32'(n == 0));
        chk("fw_empty",  32'(f_empty), 32'(n == 0));
        chk("afull",     32'(s_af),    32'(n >= 12));
        chk("fw_afull",  32'(f_af),    32'(n >= 12));
        chk("aempty",    32'(s_ae),    32'(n <= 2));
        chk("fw_aempty", 32'(f_ae),    32'(n <= 2));
        chk("overflow",  32'(s_ovf),   32'(m_ovf));
        chk("fw_ovf",    32'(f_ovf),   32'(m_ovf));
        chk("underflow", 32'(s_unf),   32'(m_unf));
        chk("fw_unf",    32'(f_unf),   32'(m_unf));
        chk("std_dout",  32'(s_dout),  32'(m_dout));
        chk("fwft_dout", 32'(f_dout),  (n == 0) ? 32'd0 : 32'(q[0]));
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, compare at the next negedge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bit was_full, was_empty;
        w_en = w; data_in = d; r_en = r; clr_err = c;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r && !was_empty) begin
            m_dout = q.pop_front();
        end
        if (w && !was_full) begin
            q.push_back(d);
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (w && was_full)  m_ovf = 1'b1;
        if (r && was_empty) m_unf = 1'b1;
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compare();
    endtask

    initial begin
        do_reset();
        chk("rst_count",  32'(s_count), 32'd0);
        chk("rst_empty",  32'(s_empty), 32'd1);
        chk("rst_aempty", 32'(s_ae),    32'd1);
        chk("rst_dout",   32'(s_dout),  32'd0);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 10) chk("afull_after_11", 32'(s_af), 32'd0);
            if (i == 11) chk("afull_after_12", 32'(s_af), 32'd1);
        end
        chk("full_16",  32'(s_full),  32'd1);
        chk("count_16", 32'(s_count), 32'd16);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("count_after_17th", 32'(s_count), 32'd16);
        chk("ovf_after_17th",   32'(s_ovf),   32'd1);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("read_seq", 32'(s_dout), 32'(i));
        end
        chk("empty_after_reads", 32'(s_empty), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("dout_hold", 32'(s_dout), 32'h0F);
        chk("unf_set",   32'(s_unf),  32'd1);

        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(s_ovf), 32'd0);
        chk("clr_unf", 32'(s_unf), 32'd0);

        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        chk("simul_count5", 32'(s_count), 32'd5);

        for (int i = 0; i < 11; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        chk("full_again", 32'(s_full), 32'd1);
        for (int i = 0; i < 40; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
        chk("simul_full_count15", 32'(s_count), 32'd15);
        chk("simul_full_ovf",     32'(s_ovf),   32'd1);

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 8'h3D, 1'b0, 1'b1);
        chk("clr_vs_set_ovf", 32'(s_ovf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_after", 32'(s_ovf), 32'd0);

        while (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_a5",       32'(f_dout),  32'hA5);
        chk("fwft_nonempty", 32'(f_empty), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_empty", 32'(f_empty), 32'd1);
        chk("fwft_zero",  32'(f_dout),  32'd0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 5));
        end

        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b1, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("pre_arst_count", 32'(s_count), 32'd10);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("pre_arst_count9", 32'(s_count), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count",  32'(s_count), 32'd0);
        chk("arst_empty",  32'(s_empty), 32'd1);
        chk("arst_aempty", 32'(s_ae),    32'd1);
        chk("arst_ovf",    32'(s_ovf),   32'd0);
        chk("arst_unf",    32'(s_unf),   32'd0);
        chk("arst_fw_cnt", 32'(f_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        for (int i = 0; i < 20; i++) step(1'b1, DW'(i + 100), ($urandom_range(0, 1) == 1), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
